remote_load_resp_wb: RTL and testbench
======================================

# remote_load_resp_wb

Response-side partner of the vanilla-core load/store unit. It accepts remote load responses returning from the network RX side, buffers them, and extracts the byte or halfword selected by the response's `bsg_manycore_load_info_s`. It then routes each result to the integer register-file writeback port, the float register-file writeback port, or the icache refill port. It also counts outstanding remote loads so that fences and scoreboard logic can tell when all responses have drained.

## Interface
Parameters:
- `data_width_p`, 32, response data width; must be 32.
- `reg_addr_width_p`, 5, register id width (`RV32_reg_addr_width_gp`).
- `fifo_els_p`, 2, response buffer depth; must be ≥2.
- `max_out_credits_p`, 32, maximum outstanding remote loads; counter width is `$clog2(max_out_credits_p+1)`.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset. Synchronous, active-low: the block is in reset when `reset_i`==0 at a rising edge.
- `resp_v_i`  in  1  response valid from network RX.
- `resp_data_i`  in  data_width_p  full response word.
- `resp_load_info_i`  in  `bsg_manycore_load_info_s`  fields: float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0].
- `resp_reg_id_i`  in  reg_addr_width_p  destination register.
- `resp_yumi_o`  out  1  response consumed this cycle.
- `load_issue_i`  in  1  a remote load or icache fetch left the tile this cycle; increments the counter.
- `int_wb_v_o` / `int_wb_rd_o` / `int_wb_data_o`  out  1 / reg_addr_width_p / data_width_p  integer RF writeback.
- `int_wb_yumi_i`  in  1  pipeline took the integer writeback.
- `float_wb_v_o` / `float_wb_rd_o` / `float_wb_data_o`  out  1 / reg_addr_width_p / data_width_p  float RF writeback.
- `float_wb_yumi_i`  in  1  pipeline took the float writeback.
- `icache_v_o` / `icache_data_o`  out  1 / data_width_p  icache refill word.
- `icache_yumi_i`  in  1  icache took the refill word.
- `out_count_o`  out  counter width  outstanding remote loads.
- `pending_o`  out  1  asserted when `out_count_o`≠0.

## Operation
- Buffer: FIFO of `fifo_els_p` entries, each holding {data, load_info, reg_id}.
  - `resp_yumi_o = resp_v_i & ~full`.
  - When full, a new response is not accepted, even if the head is popped in the same cycle.
- Routing: the head entry drives exactly one output valid.
  - icache_fetch=1 → icache port (takes priority).
  - Otherwise float_wb=1 → float port.
  - Otherwise → integer port.
- Extraction, applied on the integer path only:
  - Byte op: `b = data[8*part_sel +: 8]`; zero-extend if is_unsigned_op, else sign-extend.
  - Hex op: `h = data[16*part_sel[1] +: 16]`; extend the same way. part_sel[0] is ignored.
  - Otherwise: full word.
- Float and icache paths always pass the full word.
- Pop: the head is popped when the yumi of its selected port is asserted. A yumi asserted while that port's valid is low is a protocol error; it is ignored and flagged by a `$error` under translate_off.
- Outputs: each data/rd output is forced to 0 whenever its valid is low.
- Counter:
  - +1 on `load_issue_i`; −1 on any pop; no change when both occur in the same cycle.
  - Saturates at `max_out_credits_p` and holds at 0. Either boundary case raises a `$error` under translate_off.

## Timing
- Reset (`reset_i`==0) state:
  - FIFO empty, counter 0.
  - All `*_v_o`, `resp_yumi_o`, `pending_o` = 0; all data, rd and count outputs = 0.
- Reset mid-operation flushes all buffered responses and clears the counter on the same edge; in-flight data is dropped.
- Default latency: a response accepted at edge N appears on its output port in cycle N+1 (registered).
- Throughput: one pop per cycle. A simultaneous push and pop when not full keeps occupancy constant.
- FIFO order is preserved across all three ports; a stalled head blocks the entries behind it.

## Configuration
- `REMOTE_LOAD_RESP_BYPASS_EN` defined:
  - When the FIFO is empty and `resp_v_i`=1, the response drives its output port combinationally in the same cycle.
  - If the matching yumi is also asserted that cycle, the response is consumed without being enqueued (`resp_yumi_o`=1, occupancy stays 0).
  - If not, it is enqueued as normal.
- Not defined: no bypass path. Latency is always 1 cycle and outputs depend only on registered state.

## Test plan
- Byte load: data=0x80FF7F01, is_byte_op, part_sel=2, signed, reg_id=5 → `int_wb_rd_o`=5, `int_wb_data_o`=0xFFFFFFFF; the same response with is_unsigned_op → 0x000000FF.
- Hex load: data=0x8001_7FFE, is_hex_op, part_sel=3, signed → 0xFFFF8001; with part_sel=0 → 0x00007FFE.
- Routing:
  - Three responses back-to-back (icache_fetch=1; float_wb=1; plain) with all yumis held high → icache, float, integer ports valid on consecutive cycles, in order.
  - Holding `float_wb_yumi_i` low on the second response stalls it and the third.
- Full/backpressure: with `fifo_els_p`=2 and all yumis low, drive 3 responses → `resp_yumi_o`=1,1,0; after one pop, the third is accepted.
- Counter: 4 `load_issue_i` pulses, then a cycle with issue and pop together, then 4 pops → `out_count_o` = 4, 4, 0 and `pending_o` falls when the count reaches 0. Pulse `reset_i`=0 with 1 entry buffered → all valids 0 and count 0 on the next cycle.
- Bypass, with `REMOTE_LOAD_RESP_BYPASS_EN` defined: empty FIFO, `resp_v_i` and `int_wb_yumi_i` asserted in the same cycle → `int_wb_v_o`=1 that cycle and occupancy stays 0. Without the macro → `int_wb_v_o`=1 one cycle later.

Source files
------------

// File: rtl/remote_load_resp_wb.sv
// Buffers remote load responses, extracts sub-word results and routes them to int/float/icache.
// Define REMOTE_LOAD_RESP_BYPASS_EN to let a response skip an empty buffer in the same cycle.
module remote_load_resp_wb #(
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned reg_addr_width_p  = 5,
    parameter int unsigned fifo_els_p        = 2,
    parameter int unsigned max_out_credits_p = 32
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     resp_v_i,
    input  logic [data_width_p-1:0]                  resp_data_i,
    input  logic [6:0]                               resp_load_info_i,
    input  logic [reg_addr_width_p-1:0]              resp_reg_id_i,
    output logic                                     resp_yumi_o,
    input  logic                                     load_issue_i,
    output logic                                     int_wb_v_o,
    output logic [reg_addr_width_p-1:0]              int_wb_rd_o,
    output logic [data_width_p-1:0]                  int_wb_data_o,
    input  logic                                     int_wb_yumi_i,
    output logic                                     float_wb_v_o,
    output logic [reg_addr_width_p-1:0]              float_wb_rd_o,
    output logic [data_width_p-1:0]                  float_wb_data_o,
    input  logic                                     float_wb_yumi_i,
    output logic                                     icache_v_o,
    output logic [data_width_p-1:0]                  icache_data_o,
    input  logic                                     icache_yumi_i,
    output logic [$clog2(max_out_credits_p+1)-1:0]   out_count_o,
    output logic                                     pending_o
);

    localparam int unsigned PtrW = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int unsigned OccW = $clog2(fifo_els_p + 1);
    localparam int unsigned CntW = $clog2(max_out_credits_p + 1);

    // load_info packing: {float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel}
    localparam int unsigned InfoFloat    = 6;
    localparam int unsigned InfoIcache   = 5;
    localparam int unsigned InfoUnsigned = 4;
    localparam int unsigned InfoByte     = 3;
    localparam int unsigned InfoHex      = 2;

    logic [data_width_p-1:0]     data_q [fifo_els_p];
    logic [6:0]                  info_q [fifo_els_p];
    logic [reg_addr_width_p-1:0] rd_q   [fifo_els_p];

    logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic                        empty, full, bypass_v, head_v;
    logic [data_width_p-1:0]     head_data;
    logic [6:0]                  head_info;
    logic [reg_addr_width_p-1:0] head_rd;
    logic                        sel_icache, sel_float, sel_int;
    logic [7:0]                  byte_sel;
    logic [15:0]                 hex_sel;
    logic                        ext_sign;
    logic [data_width_p-1:0]     int_data;
    logic                        pop, bypass_pop, fifo_pop, push;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OccW'(fifo_els_p));

`ifdef REMOTE_LOAD_RESP_BYPASS_EN
    assign bypass_v = empty & resp_v_i & reset_i;
`else
    assign bypass_v = 1'b0;
`endif

    always_comb begin
        head_v = ~empty | bypass_v;
        if (bypass_v) begin
            head_data = resp_data_i;
            head_info = resp_load_info_i;
            head_rd   = resp_reg_id_i;
        end else begin
            head_data = data_q[rptr_q];
            head_info = info_q[rptr_q];
            head_rd   = rd_q[rptr_q];
        end
    end

    // icache refill outranks float writeback, which outranks integer writeback
    assign sel_icache = head_v & head_info[InfoIcache];
    assign sel_float  = head_v & ~head_info[InfoIcache] & head_info[InfoFloat];
    assign sel_int    = head_v & ~head_info[InfoIcache] & ~head_info[InfoFloat];

    always_comb begin
        byte_sel = 8'h00;
        case (head_info[1:0])
            2'd0:    byte_sel = head_data[7:0];
            2'd1:    byte_sel = head_data[15:8];
            2'd2:    byte_sel = head_data[23:16];
            default: byte_sel = head_data[31:24];
        endcase
        hex_sel  = head_info[1] ? head_data[31:16] : head_data[15:0];
        ext_sign = 1'b0;
        if (head_info[InfoByte]) begin
            ext_sign = ~head_info[InfoUnsigned] & byte_sel[7];
            int_data = {{(data_width_p-8){ext_sign}}, byte_sel};
        end else if (head_info[InfoHex]) begin
            ext_sign = ~head_info[InfoUnsigned] & hex_sel[15];
            int_data = {{(data_width_p-16){ext_sign}}, hex_sel};
        end else begin
            int_data = head_data;
        end
    end

    assign int_wb_v_o      = sel_int;
    assign int_wb_rd_o     = sel_int ? head_rd : '0;
    assign int_wb_data_o   = sel_int ? int_data : '0;
    assign float_wb_v_o    = sel_float;
    assign float_wb_rd_o   = sel_float ? head_rd : '0;
    assign float_wb_data_o = sel_float ? head_data : '0;
    assign icache_v_o      = sel_icache;
    assign icache_data_o   = sel_icache ? head_data : '0;

    assign pop = (sel_int & int_wb_yumi_i) | (sel_float & float_wb_yumi_i)
               | (sel_icache & icache_yumi_i);
    assign bypass_pop  = bypass_v & pop;
    assign fifo_pop    = pop & ~bypass_pop;
    // Full blocks acceptance even when the head leaves this cycle
    assign resp_yumi_o = reset_i & resp_v_i & ~full;
    assign push        = resp_yumi_o & ~bypass_pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = (wptr_q == PtrW'(fifo_els_p - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rptr_d = (rptr_q == PtrW'(fifo_els_p - 1)) ? '0 : rptr_q + 1'b1;
        end
        if (push && !fifo_pop) begin
            occ_d = occ_q + 1'b1;
        end else if (fifo_pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_issue_i && !pop) begin
            if (cnt_q != CntW'(max_out_credits_p)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !load_issue_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wptr_q] <= resp_data_i;
            info_q[wptr_q] <= resp_load_info_i;
            rd_q[wptr_q]   <= resp_reg_id_i;
        end
    end

    assign out_count_o = cnt_q;
    assign pending_o   = (cnt_q != '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (int_wb_yumi_i && !sel_int) $error("int_wb_yumi_i without int_wb_v_o");
            if (float_wb_yumi_i && !sel_float) $error("float_wb_yumi_i without float_wb_v_o");
            if (icache_yumi_i && !sel_icache) $error("icache_yumi_i without icache_v_o");
            if (load_issue_i && !pop && cnt_q == CntW'(max_out_credits_p)) begin
                $error("outstanding load counter overflow");
            end
            if (pop && !load_issue_i && cnt_q == '0) $error("outstanding load counter underflow");
        end
    end
`endif

endmodule

// File: tb/tb_remote_load_resp_wb.sv
// Self-checking bench for remote_load_resp_wb: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_remote_load_resp_wb;

    localparam int unsigned ELS  = 2;
    localparam int unsigned MAXC = 32;
    localparam int unsigned CW   = $clog2(MAXC + 1);
`ifdef REMOTE_LOAD_RESP_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, resp_v, resp_yumi, load_issue;
    logic [31:0]   resp_data;
    logic [6:0]    resp_info;
    logic [4:0]    resp_rd;
    logic          int_v, float_v, icache_v;
    logic [4:0]    int_rd, float_rd;
    logic [31:0]   int_data, float_data, icache_data;
    logic [CW-1:0] out_count;
    logic          pending;
    logic          int_rdy, float_rdy, icache_rdy;
    logic          int_yumi, float_yumi, icache_yumi;

    // Consumers only acknowledge what is offered
    assign int_yumi    = int_rdy & int_v;
    assign float_yumi  = float_rdy & float_v;
    assign icache_yumi = icache_rdy & icache_v;

    remote_load_resp_wb #(
        .data_width_p     (32),
        .reg_addr_width_p (5),
        .fifo_els_p       (ELS),
        .max_out_credits_p(MAXC)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_n),
        .resp_v_i        (resp_v),
        .resp_data_i     (resp_data),
        .resp_load_info_i(resp_info),
        .resp_reg_id_i   (resp_rd),
        .resp_yumi_o     (resp_yumi),
        .load_issue_i    (load_issue),
        .int_wb_v_o      (int_v),
        .int_wb_rd_o     (int_rd),
        .int_wb_data_o   (int_data),
        .int_wb_yumi_i   (int_yumi),
        .float_wb_v_o    (float_v),
        .float_wb_rd_o   (float_rd),
        .float_wb_data_o (float_data),
        .float_wb_yumi_i (float_yumi),
        .icache_v_o      (icache_v),
        .icache_data_o   (icache_data),
        .icache_yumi_i   (icache_yumi),
        .out_count_o     (out_count),
        .pending_o       (pending)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  info;
        logic [4:0]  rd;
    } resp_t;

    typedef struct {
        resp_t       r;
        int          port;
        logic [31:0] exp;
    } vec_t;

    int total = 0;
    int bad = 0;
    resp_t q[$];
    int cnt_m;
    vec_t vecs[14];

    function automatic logic [6:0] mk_info(bit fw, bit ic, bit uns, bit byt, bit hex,
                                           logic [1:0] ps);
        return {fw, ic, uns, byt, hex, ps};
    endfunction

    function automatic resp_t mk_resp(logic [31:0] d, logic [6:0] i, logic [4:0] rd);
        resp_t r;
        r.data = d;
        r.info = i;
        r.rd   = rd;
        return r;
    endfunction

    function automatic vec_t mk_vec(resp_t r, int port, logic [31:0] e);
        vec_t v;
        v.r    = r;
        v.port = port;
        v.exp  = e;
        return v;
    endfunction

    // 0 = integer, 1 = float, 2 = icache
    function automatic int ref_port(resp_t r);
        if (r.info[5]) return 2;
        if (r.info[6]) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] ref_val(resp_t r);
        int unsigned v;
        int unsigned ps;
        ps = r.info[1:0];
        if (ref_port(r) != 0) return r.data;
        if (r.info[3]) begin
            v = (r.data >> (8 * ps)) & 32'hFF;
            if (!r.info[4] && v >= 128) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (r.info[2]) begin
            v = (r.data >> (16 * (ps / 2))) & 32'hFFFF;
            if (!r.info[4] && v >= 32768) v = v | 32'hFFFF_0000;
            return v;
        end
        return r.data;
    endfunction

    function automatic bit rdy_of(int p);
        if (p == 0) return int_rdy;
        if (p == 1) return float_rdy;
        if (p == 2) return icache_rdy;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_ports(input string tag, input int port, input resp_t r,
                             input logic [31:0] e);
        chk({tag, ".int_v"}, int_v, port == 0);
        chk({tag, ".float_v"}, float_v, port == 1);
        chk({tag, ".icache_v"}, icache_v, port == 2);
        chk({tag, ".int_data"}, int_data, (port == 0) ? e : 32'h0);
        chk({tag, ".int_rd"}, int_rd, (port == 0) ? r.rd : 5'h0);
        chk({tag, ".float_data"}, float_data, (port == 1) ? e : 32'h0);
        chk({tag, ".float_rd"}, float_rd, (port == 1) ? r.rd : 5'h0);
        chk({tag, ".icache_data"}, icache_data, (port == 2) ? e : 32'h0);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_check();
        @(negedge clk);
    endtask

    task automatic idle();
        resp_v     = 1'b0;
        load_issue = 1'b0;
        int_rdy    = 1'b0;
        float_rdy  = 1'b0;
        icache_rdy = 1'b0;
    endtask

    task automatic present(input resp_t r);
        resp_v    = 1'b1;
        resp_data = r.data;
        resp_info = r.info;
        resp_rd   = r.rd;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            to_drive();
            load_issue = 1'b1;
        end
        to_drive();
        load_issue = 1'b0;
    endtask

    initial begin
        resp_t none, cur, h, rt[3], bp[3];
        int p;
        bit have_head, from_q, pop_m, exp_yumi;

        none = '0;
        vecs[0]  = mk_vec(mk_resp(32'h80FF7F01, mk_info(0, 0, 0, 1, 0, 2), 5), 0, 32'hFFFFFFFF);
        vecs[1]  = mk_vec(mk_resp(32'h80FF7F01, mk_info(0, 0, 1, 1, 0, 2), 5), 0, 32'h000000FF);
        vecs[2]  = mk_vec(mk_resp(32'h80017FFE, mk_info(0, 0, 0, 0, 1, 3), 9), 0, 32'hFFFF8001);
        vecs[3]  = mk_vec(mk_resp(32'h80017FFE, mk_info(0, 0, 0, 0, 1, 0), 9), 0, 32'h00007FFE);
        vecs[4]  = mk_vec(mk_resp(32'h80FF7F01, mk_info(0, 0, 0, 1, 0, 0), 1), 0, 32'h00000001);
        vecs[5]  = mk_vec(mk_resp(32'h80FF7F01, mk_info(0, 0, 0, 1, 0, 1), 2), 0, 32'h0000007F);
        vecs[6]  = mk_vec(mk_resp(32'h80FF7F01, mk_info(0, 0, 0, 1, 0, 3), 4), 0, 32'hFFFFFF80);
        vecs[7]  = mk_vec(mk_resp(32'h80FF7F01, mk_info(0, 0, 1, 1, 0, 3), 6), 0, 32'h00000080);
        vecs[8]  = mk_vec(mk_resp(32'h80017FFE, mk_info(0, 0, 1, 0, 1, 1), 8), 0, 32'h00007FFE);
        vecs[9]  = mk_vec(mk_resp(32'h80017FFE, mk_info(0, 0, 1, 0, 1, 2), 10), 0, 32'h00008001);
        vecs[10] = mk_vec(mk_resp(32'hDEADBEEF, mk_info(0, 0, 0, 0, 0, 1), 31), 0, 32'hDEADBEEF);
        vecs[11] = mk_vec(mk_resp(32'h80FF7F01, mk_info(1, 0, 0, 1, 0, 2), 3), 1, 32'h80FF7F01);
        vecs[12] = mk_vec(mk_resp(32'h80017FFE, mk_info(1, 1, 0, 0, 1, 3), 0), 2, 32'h80017FFE);
        vecs[13] = mk_vec(mk_resp(32'h7FFF0000, mk_info(0, 0, 0, 0, 1, 2), 12), 0, 32'h00007FFF);

        // Reset with a response waiting on the network side
        reset_n = 1'b0;
        idle();
        present(vecs[0].r);
        repeat (3) @(posedge clk);
        to_check();
        chk("rst.yumi", resp_yumi, 1'b0);
        chk_ports("rst", -1, none, 32'h0);
        chk("rst.count", out_count, 0);
        chk("rst.pending", pending, 1'b0);
        to_drive();
        reset_n = 1'b1;
        idle();

        foreach (vecs[i]) begin
            to_drive();
            load_issue = 1'b1;
            to_drive();
            load_issue = 1'b0;
            present(vecs[i].r);
            to_check();
            chk($sformatf("vec%0d.acc", i), resp_yumi, 1'b1);
            to_drive();
            resp_v = 1'b0;
            to_check();
            chk_ports($sformatf("vec%0d", i), vecs[i].port, vecs[i].r, vecs[i].exp);
            chk($sformatf("vec%0d.count", i), out_count, 1);
            int_rdy    = (vecs[i].port == 0);
            float_rdy  = (vecs[i].port == 1);
            icache_rdy = (vecs[i].port == 2);
            to_drive();
            idle();
            to_check();
            chk_ports($sformatf("vec%0d.after", i), -1, none, 32'h0);
            chk($sformatf("vec%0d.count0", i), out_count, 0);
            chk($sformatf("vec%0d.pending", i), pending, 1'b0);
        end

        // Back-to-back icache, float, int with every consumer ready
        rt[0] = mk_resp(32'h11112222, mk_info(0, 1, 0, 0, 0, 0), 1);
        rt[1] = mk_resp(32'h33334444, mk_info(1, 0, 0, 1, 0, 0), 2);
        rt[2] = mk_resp(32'h55556666, mk_info(0, 0, 0, 0, 0, 0), 3);
        issue_n(3);
        int_rdy = 1'b1;
        float_rdy = 1'b1;
        icache_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) to_drive();
            if (k < 3) present(rt[k]);
            else resp_v = 1'b0;
            to_check();
            if (k - LAT >= 0 && k - LAT < 3) begin
                chk_ports($sformatf("route%0d", k), ref_port(rt[k-LAT]), rt[k-LAT],
                          rt[k-LAT].data);
            end else begin
                chk_ports($sformatf("route%0d", k), -1, none, 32'h0);
            end
        end
        chk("route.count", out_count, 0);

        // Float consumer stalls the second response and the one behind it
        issue_n(3);
        icache_rdy = 1'b1;
        int_rdy = 1'b1;
        float_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) to_drive();
            present(rt[k]);
            to_check();
            chk($sformatf("stall.acc%0d", k), resp_yumi, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            to_drive();
            resp_v = 1'b0;
            to_check();
            chk_ports($sformatf("stall.hold%0d", k), 1, rt[1], rt[1].data);
        end
        to_drive();
        float_rdy = 1'b1;
        to_check();
        chk_ports("stall.rel", 1, rt[1], rt[1].data);
        to_drive();
        to_check();
        chk_ports("stall.next", 0, rt[2], rt[2].data);
        to_drive();
        idle();
        to_check();
        chk_ports("stall.empty", -1, none, 32'h0);
        chk("stall.count", out_count, 0);

        // Full buffer refuses a response even while its head is popped
        bp[0] = mk_resp(32'hA0000001, mk_info(0, 0, 0, 0, 0, 0), 11);
        bp[1] = mk_resp(32'hA0000002, mk_info(0, 0, 0, 0, 0, 0), 12);
        bp[2] = mk_resp(32'hA0000003, mk_info(0, 0, 0, 0, 0, 0), 13);
        issue_n(3);
        idle();
        present(bp[0]);
        to_check();
        chk("bp.acc0", resp_yumi, 1'b1);
        to_drive();
        present(bp[1]);
        to_check();
        chk("bp.acc1", resp_yumi, 1'b1);
        to_drive();
        present(bp[2]);
        to_check();
        chk("bp.full", resp_yumi, 1'b0);
        to_drive();
        int_rdy = 1'b1;
        to_check();
        chk("bp.full_pop", resp_yumi, 1'b0);
        chk_ports("bp.head0", 0, bp[0], bp[0].data);
        to_drive();
        int_rdy = 1'b0;
        to_check();
        chk("bp.acc2", resp_yumi, 1'b1);
        chk_ports("bp.head1", 0, bp[1], bp[1].data);
        to_drive();
        resp_v = 1'b0;
        int_rdy = 1'b1;
        to_check();
        chk_ports("bp.pop1", 0, bp[1], bp[1].data);
        to_drive();
        to_check();
        chk_ports("bp.pop2", 0, bp[2], bp[2].data);
        to_drive();
        idle();
        to_check();
        chk_ports("bp.empty", -1, none, 32'h0);
        chk("bp.count", out_count, 0);

        // Outstanding counter: 4 issues, issue+pop, then 4 pops
        issue_n(4);
        to_check();
        chk("cnt.four", out_count, 4);
        chk("cnt.pend", pending, 1'b1);
        to_drive();
        present(bp[0]);
        to_drive();
        resp_v = 1'b0;
        load_issue = 1'b1;
        int_rdy = 1'b1;
        to_check();
        chk("cnt.head", int_v, 1'b1);
        to_drive();
        idle();
        to_check();
        chk("cnt.same", out_count, 4);
        for (int i = 0; i < 4; i++) begin
            to_drive();
            present(bp[i % 3]);
            int_rdy = 1'b1;
            to_drive();
            resp_v = 1'b0;
            to_drive();
            to_check();
            chk($sformatf("cnt.dec%0d", i), out_count, 3 - i);
            chk($sformatf("cnt.pend%0d", i), pending, i != 3);
        end
        idle();

        // Reset mid-operation with one entry buffered
        issue_n(1);
        present(bp[0]);
        to_drive();
        resp_v = 1'b0;
        to_check();
        chk("mrst.buf", int_v, 1'b1);
        to_drive();
        reset_n = 1'b0;
        present(bp[1]);
        to_check();
        chk("mrst.yumi", resp_yumi, 1'b0);
        to_drive();
        reset_n = 1'b1;
        idle();
        to_check();
        chk_ports("mrst", -1, none, 32'h0);
        chk("mrst.count", out_count, 0);
        chk("mrst.pending", pending, 1'b0);

        // Latency of a response into an empty buffer with a ready consumer
        issue_n(1);
        present(bp[2]);
        int_rdy = 1'b1;
        to_check();
        chk("lat.yumi", resp_yumi, 1'b1);
        if (LAT == 0) chk_ports("lat.c0", 0, bp[2], bp[2].data);
        else chk_ports("lat.c0", -1, none, 32'h0);
        to_drive();
        resp_v = 1'b0;
        to_check();
        if (LAT == 0) chk_ports("lat.c1", -1, none, 32'h0);
        else chk_ports("lat.c1", 0, bp[2], bp[2].data);
        to_drive();
        idle();
        to_check();
        chk_ports("lat.c2", -1, none, 32'h0);
        chk("lat.count", out_count, 0);

        // Randomized traffic against the queue model
        cnt_m = 0;
        q.delete();
        cur = '0;
        for (int c = 0; c < 600; c++) begin
            int op;
            to_drive();
            resp_v = 1'b0;
            if (cnt_m > q.size() && $urandom_range(0, 1) == 1) begin
                op = $urandom_range(0, 2);
                cur = mk_resp($urandom(),
                              mk_info($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                                      $urandom_range(0, 1) == 1, op == 1, op == 2,
                                      2'($urandom_range(0, 3))),
                              5'($urandom_range(0, 31)));
                present(cur);
            end
            load_issue = (cnt_m < 20) && ($urandom_range(0, 2) == 0);
            int_rdy    = ($urandom_range(0, 9) < 6);
            float_rdy  = ($urandom_range(0, 9) < 6);
            icache_rdy = ($urandom_range(0, 9) < 6);
            to_check();
            exp_yumi = resp_v && (q.size() < ELS);
            chk("rnd.yumi", resp_yumi, exp_yumi);
            have_head = 1'b0;
            from_q = 1'b0;
            h = '0;
            if (q.size() > 0) begin
                h = q[0];
                have_head = 1'b1;
                from_q = 1'b1;
            end else if (LAT == 0 && resp_v) begin
                h = cur;
                have_head = 1'b1;
            end
            p = have_head ? ref_port(h) : -1;
            chk_ports("rnd", p, h, have_head ? ref_val(h) : 32'h0);
            chk("rnd.count", out_count, cnt_m);
            chk("rnd.pending", pending, cnt_m != 0);
            pop_m = have_head && rdy_of(p);
            if (pop_m && from_q) void'(q.pop_front());
            if (exp_yumi && !(pop_m && !from_q)) q.push_back(cur);
            if (load_issue && !pop_m) cnt_m++;
            else if (pop_m && !load_issue) cnt_m--;
        end

        to_drive();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
